// File: rtl/signal_cfg_pkg.sv
// Shared widths, layout helpers and update-mode encodings for the waveform config slicer.
package signal_cfg_pkg;

    localparam int unsigned DEF_N_COMP   = 4;
    localparam int unsigned DEF_OFFSET_W = 16;
    localparam int unsigned DEF_CFG_W    = 64;
    localparam int unsigned DEF_AMP_W    = 16;
    localparam int unsigned DEF_FREQ_W   = 64;
    localparam int unsigned DEF_PHASE_W  = 64;

    localparam logic UPDATE_IMMEDIATE = 1'b0;
    localparam logic UPDATE_SYNC      = 1'b1;

    function automatic int unsigned comp_w(input int unsigned cfg_w, input int unsigned amp_w,
                                           input int unsigned freq_w,
                                           input int unsigned phase_w);
        return cfg_w + amp_w + freq_w + phase_w;
    endfunction

    function automatic int unsigned total_w(input int unsigned offset_w,
                                            input int unsigned n_comp,
                                            input int unsigned cw);
        return offset_w + n_comp * cw;
    endfunction

    // Field LSBs relative to a component's base bit.
    function automatic int unsigned amp_lsb(input int unsigned cfg_w);
        return cfg_w;
    endfunction

    function automatic int unsigned freq_lsb(input int unsigned cfg_w, input int unsigned amp_w);
        return cfg_w + amp_w;
    endfunction

    function automatic int unsigned phase_lsb(input int unsigned cfg_w, input int unsigned amp_w,
                                              input int unsigned freq_w);
        return cfg_w + amp_w + freq_w;
    endfunction

    localparam int unsigned DEF_COMP_W  = comp_w(DEF_CFG_W, DEF_AMP_W, DEF_FREQ_W, DEF_PHASE_W);
    localparam int unsigned DEF_TOTAL_W = total_w(DEF_OFFSET_W, DEF_N_COMP, DEF_COMP_W);

endpackage

// File: rtl/signal_cfg_comp_reg.sv
// One DDS component: staging register, active registers and phase-change pulse.
module signal_cfg_comp_reg
    import signal_cfg_pkg::*;
#(
    parameter int unsigned CFG_W   = DEF_CFG_W,
    parameter int unsigned AMP_W   = DEF_AMP_W,
    parameter int unsigned FREQ_W  = DEF_FREQ_W,
    parameter int unsigned PHASE_W = DEF_PHASE_W,
    localparam int unsigned COMP_W = comp_w(CFG_W, AMP_W, FREQ_W, PHASE_W)
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               cap_en_i,
    input  logic [COMP_W-1:0]  cap_data_i,
    input  logic               apply_imm_i,
    input  logic               apply_stg_i,
    output logic [CFG_W-1:0]   cfg_o,
    output logic [AMP_W-1:0]   amp_o,
    output logic [FREQ_W-1:0]  freq_o,
    output logic [PHASE_W-1:0] phase_o,
    output logic               phase_load_o
);

    localparam int unsigned AMP_LSB   = amp_lsb(CFG_W);
    localparam int unsigned FREQ_LSB  = freq_lsb(CFG_W, AMP_W);
    localparam int unsigned PHASE_LSB = phase_lsb(CFG_W, AMP_W, FREQ_W);

    logic [COMP_W-1:0]  staging_q;
    logic [COMP_W-1:0]  src;
    logic [CFG_W-1:0]   cfg_q;
    logic [AMP_W-1:0]   amp_q;
    logic [FREQ_W-1:0]  freq_q;
    logic [PHASE_W-1:0] phase_q;
    logic               phase_load_q;
    logic               apply;

    // Immediate mode bypasses staging so the word lands one cycle after cfg_valid.
    assign src   = apply_imm_i ? cap_data_i : staging_q;
    assign apply = apply_imm_i | apply_stg_i;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            staging_q    <= '0;
            cfg_q        <= '0;
            amp_q        <= '0;
            freq_q       <= '0;
            phase_q      <= '0;
            phase_load_q <= 1'b0;
        end else begin
            if (cap_en_i) begin
                staging_q <= cap_data_i;
            end
            if (apply) begin
                cfg_q        <= src[0 +: CFG_W];
                amp_q        <= src[AMP_LSB +: AMP_W];
                freq_q       <= src[FREQ_LSB +: FREQ_W];
                phase_q      <= src[PHASE_LSB +: PHASE_W];
                phase_load_q <= (src[PHASE_LSB +: PHASE_W] != phase_q);
            end else begin
                phase_load_q <= 1'b0;
            end
        end
    end

    assign cfg_o        = cfg_q;
    assign amp_o        = amp_q;
    assign freq_o       = freq_q;
    assign phase_o      = phase_q;
    assign phase_load_o = phase_load_q;

endmodule

// File: rtl/signal_cfg_shadow_slice.sv
// Double-buffered per-channel config slicer: offset plus N_COMP DDS components,
// applied immediately or atomically on the period-boundary sync strobe.
module signal_cfg_shadow_slice
    import signal_cfg_pkg::*;
#(
    parameter int unsigned N_COMP   = DEF_N_COMP,
    parameter int unsigned OFFSET_W = DEF_OFFSET_W,
    parameter int unsigned CFG_W    = DEF_CFG_W,
    parameter int unsigned AMP_W    = DEF_AMP_W,
    parameter int unsigned FREQ_W   = DEF_FREQ_W,
    parameter int unsigned PHASE_W  = DEF_PHASE_W,
    localparam int unsigned COMP_W  = comp_w(CFG_W, AMP_W, FREQ_W, PHASE_W),
    localparam int unsigned TOTAL_W = total_w(OFFSET_W, N_COMP, COMP_W)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [TOTAL_W-1:0]        cfg_data,
    input  logic                      cfg_valid,
    input  logic                      update_mode,
    input  logic                      sync,
    input  logic                      overrun_clr,
    output logic [OFFSET_W-1:0]       offset,
    output logic [N_COMP*CFG_W-1:0]   comp_cfg,
    output logic [N_COMP*AMP_W-1:0]   comp_amp,
    output logic [N_COMP*FREQ_W-1:0]  comp_freq,
    output logic [N_COMP*PHASE_W-1:0] comp_phase,
    output logic [N_COMP-1:0]         phase_load,
    output logic                      pending,
    output logic                      overrun,
    output logic [15:0]               update_cnt
);

    logic                apply_imm;
    logic                apply_stg;
    logic                pending_q, pending_d;
    logic                overrun_q, overrun_d;
    logic [15:0]         update_cnt_q, update_cnt_d;
    logic [OFFSET_W-1:0] offset_stg_q;
    logic [OFFSET_W-1:0] offset_q;

    assign apply_imm = cfg_valid & (update_mode == UPDATE_IMMEDIATE);
    assign apply_stg = sync & pending_q & (update_mode == UPDATE_SYNC);

    always_comb begin
        pending_d    = pending_q;
        overrun_d    = overrun_q & ~overrun_clr;
        update_cnt_d = update_cnt_q;
        if (update_mode == UPDATE_IMMEDIATE) begin
            // Any stale staged word from sync mode is dropped by the immediate apply.
            if (cfg_valid) begin
                pending_d = 1'b0;
            end
        end else begin
            if (cfg_valid) begin
                pending_d = 1'b1;
            end else if (apply_stg) begin
                pending_d = 1'b0;
            end
            // A same-cycle apply drains the old word, so the new one is not an overrun.
            if (cfg_valid && pending_q && !apply_stg) begin
                overrun_d = 1'b1;
            end
        end
        if (apply_imm || apply_stg) begin
            update_cnt_d = update_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q    <= 1'b0;
            overrun_q    <= 1'b0;
            update_cnt_q <= '0;
            offset_stg_q <= '0;
            offset_q     <= '0;
        end else begin
            pending_q    <= pending_d;
            overrun_q    <= overrun_d;
            update_cnt_q <= update_cnt_d;
            if (cfg_valid) begin
                offset_stg_q <= cfg_data[OFFSET_W-1:0];
            end
            if (apply_imm) begin
                offset_q <= cfg_data[OFFSET_W-1:0];
            end else if (apply_stg) begin
                offset_q <= offset_stg_q;
            end
        end
    end

    for (genvar k = 0; k < N_COMP; k++) begin : g_comp
        signal_cfg_comp_reg #(
            .CFG_W  (CFG_W),
            .AMP_W  (AMP_W),
            .FREQ_W (FREQ_W),
            .PHASE_W(PHASE_W)
        ) u_comp (
            .clk_i       (clk),
            .reset_i     (reset),
            .cap_en_i    (cfg_valid),
            .cap_data_i  (cfg_data[OFFSET_W + k*COMP_W +: COMP_W]),
            .apply_imm_i (apply_imm),
            .apply_stg_i (apply_stg),
            .cfg_o       (comp_cfg[k*CFG_W +: CFG_W]),
            .amp_o       (comp_amp[k*AMP_W +: AMP_W]),
            .freq_o      (comp_freq[k*FREQ_W +: FREQ_W]),
            .phase_o     (comp_phase[k*PHASE_W +: PHASE_W]),
            .phase_load_o(phase_load[k])
        );
    end

    assign offset     = offset_q;
    assign pending    = pending_q;
    assign overrun    = overrun_q;
    assign update_cnt = update_cnt_q;

endmodule

// File: tb/tb_signal_cfg_shadow_slice.sv
// Directed bench for signal_cfg_shadow_slice at default widths.
module tb_signal_cfg_shadow_slice;
    import signal_cfg_pkg::*;

    localparam int unsigned NC  = DEF_N_COMP;
    localparam int unsigned OW  = DEF_OFFSET_W;
    localparam int unsigned CW  = DEF_CFG_W;
    localparam int unsigned AW  = DEF_AMP_W;
    localparam int unsigned FW  = DEF_FREQ_W;
    localparam int unsigned PW  = DEF_PHASE_W;
    localparam int unsigned CPW = DEF_COMP_W;
    localparam int unsigned TW  = DEF_TOTAL_W;

    logic            clk = 1'b0;
    logic            reset;
    logic [TW-1:0]   cfg_data;
    logic            cfg_valid;
    logic            update_mode;
    logic            sync;
    logic            overrun_clr;
    logic [OW-1:0]   offset;
    logic [NC*CW-1:0] comp_cfg;
    logic [NC*AW-1:0] comp_amp;
    logic [NC*FW-1:0] comp_freq;
    logic [NC*PW-1:0] comp_phase;
    logic [NC-1:0]   phase_load;
    logic            pending;
    logic            overrun;
    logic [15:0]     update_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    logic [TW-1:0] base_w, w;

    signal_cfg_shadow_slice dut (
        .clk        (clk),
        .reset      (reset),
        .cfg_data   (cfg_data),
        .cfg_valid  (cfg_valid),
        .update_mode(update_mode),
        .sync       (sync),
        .overrun_clr(overrun_clr),
        .offset     (offset),
        .comp_cfg   (comp_cfg),
        .comp_amp   (comp_amp),
        .comp_freq  (comp_freq),
        .comp_phase (comp_phase),
        .phase_load (phase_load),
        .pending    (pending),
        .overrun    (overrun),
        .update_cnt (update_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [TW-1:0] set_freq(input logic [TW-1:0] x, input int k,
                                                input logic [63:0] v);
        logic [TW-1:0] r = x;
        r[OW + k*CPW + CW + AW +: FW] = v;
        return r;
    endfunction

    function automatic logic [TW-1:0] set_phase(input logic [TW-1:0] x, input int k,
                                                 input logic [63:0] v);
        logic [TW-1:0] r = x;
        r[OW + k*CPW + CW + AW + FW +: PW] = v;
        return r;
    endfunction

    function automatic logic [TW-1:0] set_amp(input logic [TW-1:0] x, input int k,
                                               input logic [15:0] v);
        logic [TW-1:0] r = x;
        r[OW + k*CPW + CW +: AW] = v;
        return r;
    endfunction

    initial begin
        reset = 1'b1; cfg_data = '0; cfg_valid = 1'b0; update_mode = UPDATE_IMMEDIATE;
        sync = 1'b0; overrun_clr = 1'b0;
        step(); step();
        reset = 1'b0;
        step();
        check("rst_offset", 64'(offset), 64'h0);
        check("rst_freq", 64'(comp_freq[FW +: FW]), 64'h0);
        check("rst_pending", 64'(pending), 64'h0);
        check("rst_overrun", 64'(overrun), 64'h0);
        check("rst_cnt", 64'(update_cnt), 64'h0);
        check("rst_pload", 64'(phase_load), 64'h0);

        // Immediate mode: comp1 freq/phase.
        base_w = set_phase(set_freq('0, 1, 64'h1000), 1, 64'h55);
        cfg_data = base_w; cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        check("imm_freq1", comp_freq[FW +: FW], 64'h1000);
        check("imm_phase1", comp_phase[PW +: PW], 64'h55);
        check("imm_pload", 64'(phase_load), 64'h2);
        check("imm_cnt", 64'(update_cnt), 64'h1);
        check("imm_pending", 64'(pending), 64'h0);
        step();
        check("imm_pload_pulse", 64'(phase_load), 64'h0);

        // Sync mode: offset staged until sync.
        update_mode = UPDATE_SYNC;
        base_w[OW-1:0] = 16'h1234;
        cfg_data = base_w; cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        check("sync_offset_held", 64'(offset), 64'h0);
        check("sync_pending", 64'(pending), 64'h1);
        repeat (4) step();
        check("sync_offset_wait", 64'(offset), 64'h0);
        sync = 1'b1;
        step();
        sync = 1'b0;
        check("sync_offset", 64'(offset), 64'h1234);
        check("sync_pending_clr", 64'(pending), 64'h0);
        check("sync_cnt", 64'(update_cnt), 64'h2);
        check("sync_pload_same", 64'(phase_load), 64'h0);

        // Overrun: two words before sync.
        cfg_data = set_amp(base_w, 0, 16'h100); cfg_valid = 1'b1;
        step();
        cfg_data = set_amp(base_w, 0, 16'h200);
        step();
        cfg_valid = 1'b0;
        check("ovr_set", 64'(overrun), 64'h1);
        check("ovr_amp_held", 64'(comp_amp[0 +: AW]), 64'h0);
        sync = 1'b1;
        step();
        sync = 1'b0;
        check("ovr_amp_applied", 64'(comp_amp[0 +: AW]), 64'h200);
        check("ovr_sticky", 64'(overrun), 64'h1);
        check("ovr_cnt", 64'(update_cnt), 64'h3);
        overrun_clr = 1'b1;
        step();
        overrun_clr = 1'b0;
        check("ovr_clr", 64'(overrun), 64'h0);

        // Set wins over clear in the same cycle.
        cfg_data = set_amp(base_w, 0, 16'h300); cfg_valid = 1'b1;
        step();
        cfg_data = set_amp(base_w, 0, 16'h400); overrun_clr = 1'b1;
        step();
        cfg_valid = 1'b0; overrun_clr = 1'b0;
        check("ovr_set_wins", 64'(overrun), 64'h1);
        overrun_clr = 1'b1;
        step();
        overrun_clr = 1'b0;
        check("ovr_clr2", 64'(overrun), 64'h0);

        // Simultaneous cfg_valid and sync: old word applied, new word pending.
        w = set_phase(set_amp(base_w, 0, 16'h500), 3, 64'h77);
        cfg_data = w; cfg_valid = 1'b1; sync = 1'b1;
        step();
        cfg_valid = 1'b0; sync = 1'b0;
        check("simul_amp_old", 64'(comp_amp[0 +: AW]), 64'h400);
        check("simul_pending", 64'(pending), 64'h1);
        check("simul_no_ovr", 64'(overrun), 64'h0);
        check("simul_cnt", 64'(update_cnt), 64'h4);
        sync = 1'b1;
        step();
        sync = 1'b0;
        check("simul_amp_new", 64'(comp_amp[0 +: AW]), 64'h500);
        check("simul_phase3", comp_phase[3*PW +: PW], 64'h77);
        check("simul_pload3", 64'(phase_load), 64'h8);
        check("simul_pending_clr", 64'(pending), 64'h0);
        sync = 1'b1;
        step();
        sync = 1'b0;
        check("idle_sync_cnt", 64'(update_cnt), 64'h5);
        check("idle_sync_pload", 64'(phase_load), 64'h0);

        // Mode switch 1->0 while pending discards staging.
        cfg_data = set_amp(w, 0, 16'h600); cfg_valid = 1'b1;
        step();
        check("sw_pending", 64'(pending), 64'h1);
        update_mode = UPDATE_IMMEDIATE;
        w = set_amp(w, 0, 16'h700);
        cfg_data = w;
        step();
        cfg_valid = 1'b0;
        check("sw_amp", 64'(comp_amp[0 +: AW]), 64'h700);
        check("sw_pending_clr", 64'(pending), 64'h0);
        check("sw_cnt", 64'(update_cnt), 64'h6);
        sync = 1'b1;
        step();
        sync = 1'b0;
        check("sw_sync_ignored", 64'(update_cnt), 64'h6);

        // Reset while pending.
        update_mode = UPDATE_SYNC;
        cfg_data = set_amp(w, 0, 16'h800); cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0; reset = 1'b1;
        step();
        reset = 1'b0;
        check("mrst_pending", 64'(pending), 64'h0);
        check("mrst_offset", 64'(offset), 64'h0);
        check("mrst_amp", 64'(comp_amp[0 +: AW]), 64'h0);
        check("mrst_cnt", 64'(update_cnt), 64'h0);
        sync = 1'b1;
        step();
        sync = 1'b0;
        check("mrst_sync_nop", 64'(comp_amp[0 +: AW]), 64'h0);

        // Counter wrap with identical reapplies.
        update_mode = UPDATE_IMMEDIATE;
        cfg_data = w; cfg_valid = 1'b1;
        step();
        check("wrap_first_pload", 64'(phase_load), 64'ha);
        step();
        check("wrap_same_pload", 64'(phase_load), 64'h0);
        check("wrap_cnt2", 64'(update_cnt), 64'h2);
        repeat (65534) step();
        cfg_valid = 1'b0;
        check("wrap_cnt", 64'(update_cnt), 64'h0);
        check("wrap_amp", 64'(comp_amp[0 +: AW]), 64'h700);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
